probe_scan_ctrl: RTL and testbench

- Shares one multiplexed LED matrix (ROWS row strobes x COLS column drivers) among ROWS*COLS probed signals.
- Each channel has logic-probe behaviour: it tracks a steady level, and blinks at the blink rate if it saw the opposite level during the last blink window.
- Contains an internal blink prescaler (no separate slow clock), the per-channel activity latches, and the row-scan sequencer with inter-row blanking.
- Sits at the board top level between internal debug signals and the front-panel LED matrix.

---
 rtl/probe_scan_if.sv | 23 ++
 rtl/probe_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_probe_scan_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/probe_scan_if.sv
// Front-panel scan bundle: probed signals and controls in, LED matrix drive out.
interface probe_scan_if #(
   parameter int ROWS = 2,
   parameter int COLS = 4
);
   logic [ROWS*COLS-1:0] probe_in;
   logic                 hold;
   logic                 lamp_test;
   logic [ROWS-1:0]      row_sel;
   logic [COLS-1:0]      col_data;
   logic                 blink_tick;
   logic                 frame_start;

   modport master (
      output probe_in, hold, lamp_test,
      input  row_sel, col_data, blink_tick, frame_start
   );

   modport slave (
      input  probe_in, hold, lamp_test,
      output row_sel, col_data, blink_tick, frame_start
   );
endinterface

// File: rtl/probe_scan_ctrl.sv
// Logic-probe LED matrix controller: per-channel activity latches, blink prescaler
// and a row-scan sequencer with blanking between rows.
module probe_scan_ctrl #(
   parameter int ROWS  = 2,
   parameter int COLS  = 4,
   parameter int DWELL = 1024,
   parameter int BLANK = 16,
   parameter int BLINK = 2**22
) (
   input  logic         clk,
   input  logic         reset,
   probe_scan_if.slave  bus
);
   localparam int N    = ROWS * COLS;
   localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int CW   = $clog2(MAXC + 1);
   localparam int PW   = $clog2(BLINK);
   localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

   typedef enum logic [0:0] {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } state_t;

   state_t          state_r, state_nx;
   logic [CW-1:0]   cnt_r, cnt_nx;
   logic [RW-1:0]   row_r, row_nx;
   logic [PW-1:0]   presc_r;
   logic            tick_s;
   logic [N-1:0]    sync1_r, sync2_r;
   logic [N-1:0]    saw0_r, saw1_r, led_r;
   logic [N-1:0]    e0_s, e1_s, led_upd_s;
   logic [ROWS-1:0] row_sel_r, row_sel_nx;
   logic [COLS-1:0] col_data_r, col_data_nx;
   logic            blink_tick_r, frame_start_r, frame_start_nx;

   assign tick_s = (presc_r == {PW{1'b0}});
   assign e0_s   = saw0_r | ~sync2_r;
   assign e1_s   = saw1_r | sync2_r;
   // A lit LED goes dark if a low was seen in the window; a dark LED lights if a high was seen.
   assign led_upd_s = (led_r & ~e0_s) | (~led_r & e1_s);

   // Blink prescaler: free-running down counter, tick on the zero count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_r      <= PW'(BLINK - 1);
         blink_tick_r <= 1'b0;
      end else begin
         presc_r      <= tick_s ? PW'(BLINK - 1) : presc_r - PW'(1);
         blink_tick_r <= tick_s;
      end
   end

   // Input synchronizers, window activity flags and LED states.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_r <= {N{1'b0}};
         sync2_r <= {N{1'b0}};
         saw0_r  <= {N{1'b0}};
         saw1_r  <= {N{1'b0}};
         led_r   <= {N{1'b0}};
      end else begin
         sync1_r <= bus.probe_in;
         sync2_r <= sync1_r;
         if (tick_s) begin
            saw0_r <= ~sync2_r;
            saw1_r <= sync2_r;
            if (!bus.hold) begin
               led_r <= led_upd_s;
            end else begin
               led_r <= led_r;
            end
         end else begin
            saw0_r <= e0_s;
            saw1_r <= e1_s;
         end
      end
   end

   // Scan FSM next state plus the output values registered from it.
   always_comb begin
      state_nx       = state_r;
      cnt_nx         = cnt_r;
      row_nx         = row_r;
      row_sel_nx     = {ROWS{1'b0}};
      col_data_nx    = {COLS{1'b0}};
      frame_start_nx = 1'b0;
      case (state_r)
         ST_BLANK: begin
            if (cnt_r == {CW{1'b0}}) begin
               state_nx = ST_DRIVE;
               cnt_nx   = CW'(DWELL - 1);
            end else begin
               cnt_nx = cnt_r - CW'(1);
            end
         end
         ST_DRIVE: begin
            if (cnt_r == {CW{1'b0}}) begin
               row_nx   = (row_r == RW'(ROWS - 1)) ? {RW{1'b0}} : row_r + RW'(1);
               state_nx = ST_BLANK;
               cnt_nx   = CW'(BLANK - 1);
            end else begin
               cnt_nx = cnt_r - CW'(1);
            end
         end
         default: begin
            state_nx = ST_BLANK;
            cnt_nx   = CW'(BLANK - 1);
            row_nx   = {RW{1'b0}};
         end
      endcase
      if (state_nx == ST_DRIVE) begin
         row_sel_nx[row_nx] = 1'b1;
         col_data_nx        = bus.lamp_test ? {COLS{1'b1}} : led_r[row_nx*COLS +: COLS];
         frame_start_nx     = (state_r == ST_BLANK) && (row_nx == {RW{1'b0}});
      end else begin
         row_sel_nx     = {ROWS{1'b0}};
         col_data_nx    = {COLS{1'b0}};
         frame_start_nx = 1'b0;
      end
   end

   // Scan FSM state and registered matrix outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r       <= ST_BLANK;
         cnt_r         <= CW'(BLANK - 1);
         row_r         <= {RW{1'b0}};
         row_sel_r     <= {ROWS{1'b0}};
         col_data_r    <= {COLS{1'b0}};
         frame_start_r <= 1'b0;
      end else begin
         state_r       <= state_nx;
         cnt_r         <= cnt_nx;
         row_r         <= row_nx;
         row_sel_r     <= row_sel_nx;
         col_data_r    <= col_data_nx;
         frame_start_r <= frame_start_nx;
      end
   end

   assign bus.row_sel     = row_sel_r;
   assign bus.col_data    = col_data_r;
   assign bus.blink_tick  = blink_tick_r;
   assign bus.frame_start = frame_start_r;
endmodule

// File: tb/tb_probe_scan_ctrl.sv
// Randomized bench for probe_scan_ctrl against a frame/window-level reference model.
module tb_probe_scan_ctrl;
   localparam int ROWS  = 2;
   localparam int COLS  = 4;
   localparam int DWELL = 4;
   localparam int BLANK = 1;
   localparam int BLINK = 16;
   localparam int N     = ROWS * COLS;

   logic clk;
   logic reset;
   probe_scan_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

   probe_scan_ctrl #(
      .ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .BLANK(BLANK), .BLINK(BLINK)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // stimulus values applied at the next rising edge
   logic [N-1:0] probe_v;
   logic         hold_v;
   logic         lamp_v;

   // reference model: edges since reset release, 2-clock input latency, window flags, LEDs
   int           k;
   logic [N-1:0] d1, d2;
   logic [N-1:0] win_low, win_high, led_m;
   logic         last_drv;
   int           last_row;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      k        = 0;
      d1       = '0;
      d2       = '0;
      win_low  = '0;
      win_high = '0;
      led_m    = '0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_row"}, 32'(bus.row_sel), 32'd0);
      chk({tag, "_col"}, 32'(bus.col_data), 32'd0);
      chk({tag, "_bt"},  32'(bus.blink_tick), 32'd0);
      chk({tag, "_fs"},  32'(bus.frame_start), 32'd0);
   endtask

   // one clock: apply inputs, advance model at the edge, compare 1 time unit later
   task automatic step();
      int           c, r, o;
      logic         drv, tick;
      logic [N-1:0] s, lo, hi;
      logic [ROWS-1:0] exp_row;
      logic [COLS-1:0] exp_col;
      bus.probe_in  = probe_v;
      bus.hold      = hold_v;
      bus.lamp_test = lamp_v;
      @(posedge clk);
      k++;
      s  = d2;
      d2 = d1;
      d1 = probe_v;
      c   = k - 1;
      r   = (c / (DWELL + BLANK)) % ROWS;
      o   = c % (DWELL + BLANK);
      drv = (o < DWELL);
      exp_row = '0;
      exp_col = '0;
      if (drv) begin
         exp_row[r] = 1'b1;
         exp_col    = lamp_v ? {COLS{1'b1}} : led_m[r*COLS +: COLS];
      end
      tick = ((k % BLINK) == 0);
      lo = win_low | ~s;
      hi = win_high | s;
      if (tick) begin
         if (!hold_v) begin
            for (int i = 0; i < N; i++) begin
               if (led_m[i] && lo[i])       led_m[i] = 1'b0;
               else if (!led_m[i] && hi[i]) led_m[i] = 1'b1;
            end
         end
         win_low  = ~s;
         win_high = s;
      end else begin
         win_low  = lo;
         win_high = hi;
      end
      last_drv = drv;
      last_row = r;
      #1;
      chk("row_sel",     32'(bus.row_sel),     32'(exp_row));
      chk("col_data",    32'(bus.col_data),    32'(exp_col));
      chk("blink_tick",  32'(bus.blink_tick),  32'(tick));
      chk("frame_start", 32'(bus.frame_start), 32'(drv && r == 0 && o == 0));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int found;
      clk     = 1'b0;
      reset   = 1'b1;
      probe_v = '0;
      hold_v  = 1'b0;
      lamp_v  = 1'b0;
      bus.probe_in  = '0;
      bus.hold      = 1'b0;
      bus.lamp_test = 1'b0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      reset = 1'b0;

      // idle: scan pattern, frame pulses, blink ticks, dark columns
      run(40);

      // steady pattern
      probe_v = 8'h05;
      run(60);

      // channel 6 toggling every 3 clocks
      probe_v = 8'h00;
      for (int i = 0; i < 96; i++) begin
         if ((i % 3) == 0) probe_v[6] = ~probe_v[6];
         step();
      end

      // all high, then hold across three ticks of all-low, then release
      probe_v = 8'hFF;
      run(40);
      hold_v  = 1'b1;
      probe_v = 8'h00;
      run(3 * BLINK);
      hold_v  = 1'b0;
      run(40);

      // lamp test with idle probes
      lamp_v = 1'b1;
      run(30);
      lamp_v = 1'b0;
      run(20);

      // random traffic: slowly changing probes, occasional hold and lamp test
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) probe_v = N'($urandom);
         if ($urandom_range(0, 31) == 0) hold_v = ~hold_v;
         if ($urandom_range(0, 15) == 0) lamp_v = ~lamp_v;
         step();
      end
      hold_v = 1'b0;
      lamp_v = 1'b0;

      // pattern A5, then asynchronous reset in the middle of a row-1 drive
      probe_v = 8'hA5;
      run(40);
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         step();
         if (last_drv && last_row == 1 && led_m == 8'hA5) found = 1;
      end
      chk("row1_reached", 32'(found), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check_zero("async_rst");
      @(posedge clk);
      #1;
      check_zero("rst_held");
      reset = 1'b0;
      model_clear();
      run(30);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
